// File: rtl/com_sfifo_tpram.sv
// rtl/com_sfifo_tpram.sv - FWFT FIFO over a two-port RAM shell with a 2-entry output buffer
// Optional high watermark on max_level: define COM_SFIFO_WATERMARK_EN.
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

module com_tpram2ck_shell #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int MEM_USER = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_clk,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [`COM_SYS_W-1:0] sys_cfg
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              unused_shell;

  assign unused_shell = ^{sys_cfg, MEM_USER[0]};
  assign rd_data      = rd_data_q;

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end
endmodule

module com_sfifo_tpram #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int MEM_USER = 0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int LVL_W   = $clog2(DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`COM_SYS_W-1:0] sys_cfg,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [LVL_W-1:0]      level,
  output logic                  empty,
  output logic [LVL_W-1:0]      max_level
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  ram_cnt_q, ram_cnt_d, level_q, level_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d, obuf_post;
  logic [DATA_W-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d, rd_data;
  logic              push, pop, rd_en;

  assign in_ready  = (ram_cnt_q < LVL_W'(DEPTH));
  assign out_valid = (obuf_cnt_q != 2'd0);
  assign out_data  = obuf0_q;
  assign level     = level_q;
  assign empty     = (level_q == '0);

  always_comb begin
    push  = in_valid & in_ready & ~clr;
    pop   = out_valid & out_ready & ~clr;
    // Prefetch only while the buffer plus the in-flight read leaves a free slot.
    rd_en = ~clr && (ram_cnt_q != '0) &&
            (({1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, pop}));

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);

    ram_cnt_d     = ram_cnt_q + LVL_W'(push) - LVL_W'(rd_en);
    rd_inflight_d = rd_en;

    // Head only shifts when a second entry exists, so out_data holds once empty.
    obuf_post = obuf_cnt_q - {1'b0, pop};
    obuf0_d   = obuf0_q;
    obuf1_d   = obuf1_q;
    if (pop && (obuf_cnt_q == 2'd2)) obuf0_d = obuf1_q;
    if (rd_inflight_q) begin
      if (obuf_post == 2'd0) obuf0_d = rd_data;
      else                   obuf1_d = rd_data;
    end
    obuf_cnt_d = obuf_post + {1'b0, rd_inflight_q};

    if (clr) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      ram_cnt_d     = '0;
      rd_inflight_d = 1'b0;
      obuf_cnt_d    = 2'd0;
      obuf0_d       = '0;
      obuf1_d       = '0;
    end
    level_d = ram_cnt_d + LVL_W'(rd_inflight_d) + LVL_W'(obuf_cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      obuf_cnt_q    <= 2'd0;
      obuf0_q       <= '0;
      obuf1_q       <= '0;
      level_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_cnt_q    <= obuf_cnt_d;
      obuf0_q       <= obuf0_d;
      obuf1_q       <= obuf1_d;
      level_q       <= level_d;
    end
  end

`ifdef COM_SFIFO_WATERMARK_EN
  logic [LVL_W-1:0] max_level_q, max_level_d;

  always_comb begin
    max_level_d = (level_q > max_level_q) ? level_q : max_level_q;
    if (clr) max_level_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_level_q <= '0;
    else        max_level_q <= max_level_d;
  end

  assign max_level = max_level_q;
`else
  assign max_level = '0;
`endif

  com_tpram2ck_shell #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MEM_USER (MEM_USER)
  ) u_ram (
    .wr_clk  (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_clk  (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data),
    .sys_cfg (sys_cfg)
  );

`ifndef SYNTHESIS
  a_push_ready: assert property (@(posedge clk) disable iff (!rst_n) push |-> in_ready);
  a_obuf_bound: assert property (@(posedge clk) disable iff (!rst_n)
                  ({1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q}) <= 3'd2);
  a_ram_bound:  assert property (@(posedge clk) disable iff (!rst_n) ram_cnt_q <= LVL_W'(DEPTH));
`endif
endmodule

// File: tb/tb_com_sfifo_tpram.sv
// tb/tb_com_sfifo_tpram.sv - self-checking bench for com_sfifo_tpram (DEPTH 64 and DEPTH 5 instances)
`timescale 1ns/1ps
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

module tb_com_sfifo_tpram;
  logic                  clk, rst_n, clr, in_valid, out_ready, sel;
  logic [31:0]           in_data;
  logic [`COM_SYS_W-1:0] sys_cfg;

  logic        in_ready_a, out_valid_a, empty_a;
  logic [31:0] out_data_a;
  logic [6:0]  level_a, max_level_a;
  logic        in_ready_b, out_valid_b, empty_b;
  logic [31:0] out_data_b;
  logic [2:0]  level_b, max_level_b;

  logic        o_in_ready, o_out_valid, o_empty;
  logic [31:0] o_out_data;
  logic [6:0]  o_level;

  int n_cmp = 0;
  int n_bad = 0;

  com_sfifo_tpram #(.DATA_W(32), .DEPTH(64), .MEM_USER(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .sys_cfg(sys_cfg), .clr(clr),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready & ~sel), .out_data(out_data_a),
    .level(level_a), .empty(empty_a), .max_level(max_level_a));

  com_sfifo_tpram #(.DATA_W(32), .DEPTH(5), .MEM_USER(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .sys_cfg(sys_cfg), .clr(clr),
    .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready & sel), .out_data(out_data_b),
    .level(level_b), .empty(empty_b), .max_level(max_level_b));

  assign o_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign o_out_valid = sel ? out_valid_b : out_valid_a;
  assign o_empty     = sel ? empty_b     : empty_a;
  assign o_out_data  = sel ? out_data_b  : out_data_a;
  assign o_level     = sel ? {4'b0, level_b} : level_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        iv;
    logic        ordy;
    logic [31:0] din;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [6:0]  e_lvl;
  } vec_t;

  vec_t tv [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Reference: a queue of accepted words; level equals its size, the head is the next output.
  task automatic run_model(input int n_words, input int pv, input int pr, input int budget,
                           input bit stream, input int depth, input string tag);
    logic [31:0] q[$];
    int sent = 0, got = 0, cyc = 0, gaps = 0;
    bit started = 0;
    while (got < n_words && cyc < budget) begin
      in_valid  = (sent < n_words) && ($urandom_range(99) < pv);
      in_data   = stream ? sent : $urandom;
      out_ready = ($urandom_range(99) < pr);
      check({tag, "_level"}, o_level, q.size());
      check({tag, "_empty"}, o_empty, q.size() == 0);
      if (q.size() == 0) check({tag, "_ov_empty"}, o_out_valid, 0);
      if (q.size() < depth) check({tag, "_ir_room"}, o_in_ready, 1);
      if (q.size() >= depth + 2) check({tag, "_ir_full"}, o_in_ready, 0);
      if (o_out_valid && q.size() != 0) check({tag, "_data"}, o_out_data, q[0]);
      if (started && !o_out_valid) gaps++;
      if (o_out_valid) started = 1;
      if (o_out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (in_valid && o_in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_words_out"}, got, n_words);
    if (stream) check({tag, "_gaps"}, gaps, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    in_data = '0; sys_cfg = '0;
    for (int i = 0; i < 16; i++) begin
      tv[i].iv = 1'b0; tv[i].ordy = 1'b1; tv[i].din = '0;
      tv[i].e_ir = 1'b1; tv[i].e_ov = 1'b0; tv[i].e_od = '0; tv[i].e_lvl = '0;
    end
    tv[10].iv = 1'b1; tv[10].din = 32'hA5;
    tv[11].e_lvl = 7'd1;
    tv[12].e_lvl = 7'd1;
    tv[13].e_lvl = 7'd1; tv[13].e_ov = 1'b1; tv[13].e_od = 32'hA5;
    tv[14].e_od = 32'hA5;
    tv[15].e_od = 32'hA5;

    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_in_ready", o_in_ready, 1);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_level", o_level, 0);
      check("rst_empty", o_empty, 1);
    end
    check("rst_max_level", max_level_a, 0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push: latency and level trace
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vec%0d_in_ready", i), o_in_ready, tv[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), o_out_valid, tv[i].e_ov);
      check($sformatf("vec%0d_out_data", i), o_out_data, tv[i].e_od);
      check($sformatf("vec%0d_level", i), o_level, tv[i].e_lvl);
      check($sformatf("vec%0d_empty", i), o_empty, tv[i].e_lvl == 0);
      in_valid = tv[i].iv; out_ready = tv[i].ordy; in_data = tv[i].din;
      step();
    end
    idle(2);

    // Fill DEPTH+2 with the output blocked
    for (int i = 0; i < 66; i++) begin
      check("full_in_ready_pre", o_in_ready, 1);
      in_valid = 1'b1; in_data = 100 + i; out_ready = 1'b0;
      step();
    end
    in_data = 32'd999;
    for (int i = 0; i < 4; i++) begin
      check("full_in_ready", o_in_ready, 0);
      check("full_level", o_level, 66);
      step();
    end
    in_valid = 1'b0;
    check("full_out_valid", o_out_valid, 1);
    check("full_head", o_out_data, 100);
    out_ready = 1'b1;
    for (int i = 0; i < 66; i++) begin
      check("drain_valid", o_out_valid, 1);
      check("drain_data", o_out_data, 100 + i);
      step();
    end
    out_ready = 1'b0;
    check("drain_level", o_level, 0);
    check("drain_empty", o_empty, 1);
    idle(2);

    // Sustained streaming
    run_model(1000, 100, 100, 3000, 1, 64, "stream");
    idle(4);

    // clr with a read in flight
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1; in_data = 200 + i; out_ready = 1'b0;
      step();
    end
    idle(4);
    check("clr_pre_level", o_level, 21);
    out_ready = 1'b1;
    step();
    check("clr_pre_level20", o_level, 20);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("clr_level", o_level, 0);
    check("clr_out_valid", o_out_valid, 0);
    check("clr_in_ready", o_in_ready, 1);
    check("clr_empty", o_empty, 1);
    check("clr_out_data", o_out_data, 0);
    check("clr_max_level", max_level_a, 0);
    in_valid = 1'b1; in_data = 32'h3C;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    begin
      int n = 0;
      while (!o_out_valid && n < 10) begin
        step();
        n++;
      end
      check("clr_first_valid", o_out_valid, 1);
      check("clr_first_word", o_out_data, 32'h3C);
    end
    step();
    out_ready = 1'b0;
    check("clr_post_level", o_level, 0);
    idle(2);

`ifdef COM_SFIFO_WATERMARK_EN
    for (int i = 0; i < 37; i++) begin
      in_valid = 1'b1; in_data = i; out_ready = 1'b0;
      step();
    end
    idle(4);
    check("wm_fill_level", o_level, 37);
    check("wm_fill_max", max_level_a, 37);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 45; i++) step();
    out_ready = 1'b0;
    check("wm_drain_level", o_level, 0);
    check("wm_drain_max", max_level_a, 37);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("wm_clr_max", max_level_a, 0);
`else
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = i; out_ready = 1'b0;
      step();
    end
    idle(4);
    check("wm_off_max", max_level_a, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
`endif
    idle(2);

    // Random traffic on a non-power-of-2 depth
    sel = 1'b1;
    #1;
    run_model(10000, 50, 50, 60000, 0, 5, "rand5");
    idle(4);
    check("rand5_final_level", o_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
